// File: rtl/usb_rx_framer.sv
// ---------------------------------------------------------------------------
// usb_rx_framer
// Receive framer for the USB byte stream. Bytes are grouped into packets by
// an idle timeout. The first two bytes of a packet form a little-endian start
// address. Every following byte becomes an (address, data, first) write
// through a first-word fall-through FIFO with a valid/ready handshake.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   USB_FWRn, USB_D  USB write strobe (active low) and data bus
//   wr_valid/ready   FIFO head handshake
//   wr_adr/data      head write address / data
//   wr_first         head entry is the first data byte of its packet
//   pkt_done         pulse: packet with at least one data byte ended
//   err_short        pulse: packet ended with fewer than 3 bytes
//   err_long         pulse: byte MAX_PKT+1 arrived (once per packet)
//   overflow         sticky: a data byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module usb_rx_framer #(
   parameter int TIMEOUT = 8,
   parameter int MAX_PKT = 64,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        USB_FWRn,
   input  logic [7:0]  USB_D,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [15:0] wr_adr,
   output logic [7:0]  wr_data,
   output logic        wr_first,
   output logic        pkt_done,
   output logic        err_short,
   output logic        err_long,
   output logic        overflow
);

   localparam int ENTRY_W = 25;
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_P = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [7:0] TIMEOUT_P = 8'(TIMEOUT);
   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
   // MAX_PKT must stay below 128 so it fits the 7-bit byte counter
   localparam logic [6:0] MAX_CNT = 7'(MAX_PKT);

   typedef enum logic [1:0] {
      ADR_LO  = 2'd0,
      ADR_HI  = 2'd1,
      DATA    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   logic               strb_q;
   logic [7:0]         d_q;
   logic [7:0]         idle_q, idle_d;
   state_t             state_q, state_d;
   logic [15:0]        adr_q, adr_d;
   logic [6:0]         cnt_q, cnt_d;
   logic               pkt_done_q, pkt_done_d;
   logic               err_short_q, err_short_d;
   logic               err_long_q, err_long_d;
   logic               overflow_q, overflow_d;
   logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic               timeout_s;
   logic               push_s;
   logic               do_push_s;
   logic               do_pop_s;
   logic               fifo_full_s;
   logic               fifo_valid_s;
   logic               first_s;
   logic [ENTRY_W-1:0] head_s;

   // Idle counter and FIFO status; full is judged on start-of-cycle occupancy
   always_comb begin
      if (strb_q) begin
         idle_d = 8'd0;
      end else if (idle_q == TIMEOUT_P) begin
         idle_d = TIMEOUT_P;
      end else begin
         idle_d = idle_q + 8'd1;
      end
      // timeout is the cycle in which the counter reaches TIMEOUT
      timeout_s    = ~strb_q & (idle_q == TIMEOUT_M1);
      fifo_valid_s = (wr_ptr_q != rd_ptr_q);
      fifo_full_s  = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
      first_s      = (cnt_q == 7'd2);
      do_push_s    = push_s & ~fifo_full_s;
      do_pop_s     = fifo_valid_s & wr_ready;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Framing state machine: address capture, data pushes, length and timeout handling
   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      cnt_d       = cnt_q;
      push_s      = 1'b0;
      pkt_done_d  = 1'b0;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      overflow_d  = overflow_q;
      if (strb_q) begin
         case (state_q)
            ADR_LO: begin
               adr_d[7:0] = d_q;
               cnt_d      = 7'd1;
               state_d    = ADR_HI;
            end
            ADR_HI: begin
               adr_d[15:8] = d_q;
               cnt_d       = 7'd2;
               state_d     = DATA;
            end
            DATA: begin
               if (cnt_q == MAX_CNT) begin
                  state_d    = DISCARD;
                  err_long_d = 1'b1;
               end else begin
                  // address advances even when the byte is dropped, so later
                  // bytes keep their correct addresses
                  push_s = 1'b1;
                  adr_d  = adr_q + 16'd1;
                  cnt_d  = cnt_q + 7'd1;
                  if (fifo_full_s) begin
                     overflow_d = 1'b1;
                  end else begin
                     overflow_d = overflow_q;
                  end
               end
            end
            DISCARD: state_d = DISCARD;
            default: state_d = ADR_LO;
         endcase
      end else if (timeout_s) begin
         case (state_q)
            ADR_LO: state_d = ADR_LO;
            ADR_HI: begin
               state_d     = ADR_LO;
               cnt_d       = 7'd0;
               err_short_d = 1'b1;
            end
            DATA: begin
               state_d = ADR_LO;
               cnt_d   = 7'd0;
               // a 2-byte packet reaches DATA without pushing anything
               if (cnt_q == 7'd2) begin
                  err_short_d = 1'b1;
               end else begin
                  pkt_done_d = 1'b1;
               end
            end
            DISCARD: begin
               state_d    = ADR_LO;
               cnt_d      = 7'd0;
               pkt_done_d = 1'b1;
            end
            default: state_d = ADR_LO;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // All control and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strb_q      <= 1'b0;
         d_q         <= 8'h00;
         idle_q      <= TIMEOUT_P;
         state_q     <= ADR_LO;
         adr_q       <= 16'h0000;
         cnt_q       <= 7'd0;
         pkt_done_q  <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= {(FIFO_AW + 1){1'b0}};
         rd_ptr_q    <= {(FIFO_AW + 1){1'b0}};
      end else begin
         strb_q      <= ~USB_FWRn;
         d_q         <= USB_D;
         idle_q      <= idle_d;
         state_q     <= state_d;
         adr_q       <= adr_d;
         cnt_q       <= cnt_d;
         pkt_done_q  <= pkt_done_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so the head outputs read zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ENTRY_W{1'b0}};
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {adr_q, d_q, first_s};
      end
   end

   assign head_s    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign wr_valid  = fifo_valid_s;
   assign wr_adr    = head_s[24:9];
   assign wr_data   = head_s[8:1];
   assign wr_first  = head_s[0];
   assign pkt_done  = pkt_done_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_usb_rx_framer.sv
// Self-checking bench for usb_rx_framer: directed packet sequence with random
// payloads, a packet-level reference model and a pop-side monitor.
module tb_usb_rx_framer;

   localparam int TIMEOUT = 8;
   localparam int MAX_PKT = 64;
   localparam int FIFO_AW = 4;

   typedef struct packed {
      logic [15:0] adr;
      logic [7:0]  data;
      logic        first;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        USB_FWRn = 1'b1;
   logic [7:0]  USB_D = 8'h00;
   logic        wr_ready = 1'b0;
   logic        wr_valid;
   logic [15:0] wr_adr;
   logic [7:0]  wr_data;
   logic        wr_first;
   logic        pkt_done;
   logic        err_short;
   logic        err_long;
   logic        overflow;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_done = 0, n_short = 0, n_long = 0, n_writes = 0;
   int exp_done = 0, exp_short = 0, exp_long = 0, exp_writes = 0;
   int last_done_cyc = -1;
   int last_strb_cyc = 0;
   int max_gap = 0;
   bit rand_ready = 1'b0;
   bit ready_level = 1'b0;
   bit stall_prev = 1'b0;
   logic [24:0] held = 25'h0;
   logic [7:0] pkt_q[$];
   wr_t exp_q[$];

   usb_rx_framer #(.TIMEOUT(TIMEOUT), .MAX_PKT(MAX_PKT), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .rst(rst), .USB_FWRn(USB_FWRn), .USB_D(USB_D),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_adr(wr_adr),
      .wr_data(wr_data), .wr_first(wr_first), .pkt_done(pkt_done),
      .err_short(err_short), .err_long(err_long), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // consumer ready: either a held level or random with 3/4 probability
   initial forever begin
      @(posedge clk);
      #2;
      if (rand_ready) wr_ready = ($urandom_range(3, 0) != 0);
      else wr_ready = ready_level;
   end

   // monitor: pops, pulse counting, stall stability
   initial forever begin
      @(negedge clk);
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", wr_valid, 1);
            chk("stall_hold", {wr_adr, wr_data, wr_first}, held);
         end
         if (pkt_done) begin n_done++; last_done_cyc = cyc; end
         if (err_short) n_short++;
         if (err_long) n_long++;
         if (wr_valid && wr_ready) begin
            n_writes++;
            chk("unexpected_write", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_adr", wr_adr, e.adr);
               chk("wr_data", wr_data, e.data);
               chk("wr_first", wr_first, e.first);
            end
         end
         stall_prev = wr_valid && !wr_ready;
         held = {wr_adr, wr_data, wr_first};
      end
   end

   // packet-level reference: writes for bytes 3..MAX_PKT, first `keep` retained
   task automatic model_pkt(input int keep, input bit pulses);
      int n;
      int lim;
      logic [15:0] base;
      wr_t e;
      n = pkt_q.size();
      base = (n >= 2) ? {pkt_q[1], pkt_q[0]} : 16'h0000;
      lim = (n > MAX_PKT) ? MAX_PKT : n;
      for (int i = 2; i < lim; i++) begin
         if (i - 2 < keep) begin
            e.adr = base + 16'(i - 2);
            e.data = pkt_q[i];
            e.first = (i == 2);
            exp_q.push_back(e);
            exp_writes++;
         end
      end
      if (pulses) begin
         if (n >= 3) exp_done++;
         else if (n >= 1) exp_short++;
         if (n > MAX_PKT) exp_long++;
      end
   endtask

   task automatic send_range(input int lo, input int hi);
      int g;
      for (int i = lo; i < hi; i++) begin
         if (i > lo && max_gap > 0) begin
            g = $urandom_range(max_gap, 0);
            repeat (g) begin @(posedge clk); #1; USB_FWRn = 1'b1; USB_D = 8'($urandom); end
         end
         @(posedge clk); #1;
         USB_FWRn = 1'b0;
         USB_D = pkt_q[i];
      end
      @(posedge clk); #1;
      last_strb_cyc = cyc;
      USB_FWRn = 1'b1;
      USB_D = 8'($urandom);
   endtask

   task automatic send_pkt(input int keep);
      model_pkt(keep, 1'b1);
      send_range(0, pkt_q.size());
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; USB_FWRn = 1'b1; end
   endtask

   task automatic wait_drain(input string tag, input int bound);
      for (int k = 0; k < bound && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      chk(tag, exp_q.size(), 0);
   endtask

   task automatic rand_pkt(input int nbytes);
      pkt_q.delete();
      for (int i = 0; i < nbytes; i++) pkt_q.push_back(8'($urandom));
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_done"}, n_done, exp_done);
      chk({tag, "_short"}, n_short, exp_short);
      chk({tag, "_long"}, n_long, exp_long);
      chk({tag, "_writes"}, n_writes, exp_writes);
   endtask

   initial begin
      #1;
      chk("rst_valid", wr_valid, 0);
      chk("rst_adr", wr_adr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_first", wr_first, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_short", err_short, 0);
      chk("rst_long", err_long, 0);
      chk("rst_ovf", overflow, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      ready_level = 1'b1;
      idle(2);

      // basic packet and pulse timing
      pkt_q = '{8'h00, 8'h10, 8'h34, 8'h12};
      send_pkt(1000);
      idle(TIMEOUT + 5);
      wait_drain("t1_drain", 50);
      chk("t1_done_time", last_done_cyc, last_strb_cyc + TIMEOUT + 1);
      check_counts("t1");

      // short packets: 1 byte then 2 bytes
      rand_pkt(1); send_pkt(1000); idle(20);
      rand_pkt(2); send_pkt(1000); idle(20);
      check_counts("t2");

      // long packet with address wrap
      rand_pkt(66); pkt_q[0] = 8'hFE; pkt_q[1] = 8'hFF;
      send_pkt(1000);
      idle(TIMEOUT + 5);
      wait_drain("t3_drain", 100);
      check_counts("t3");

      // overflow with stalled consumer
      ready_level = 1'b0;
      idle(2);
      rand_pkt(22); pkt_q[0] = 8'h00; pkt_q[1] = 8'h02;
      model_pkt(16, 1'b1);
      send_range(0, 18);
      @(posedge clk); #1;
      chk("t4_no_ovf_yet", overflow, 0);
      chk("t4_valid", wr_valid, 1);
      send_range(18, 22);
      @(posedge clk); #1;
      chk("t4_ovf", overflow, 1);
      idle(TIMEOUT + 5);
      ready_level = 1'b1;
      wait_drain("t4_drain", 100);
      rand_pkt(5); send_pkt(1000);
      idle(TIMEOUT + 5);
      wait_drain("t4_next_drain", 50);
      chk("t4_ovf_sticky", overflow, 1);
      check_counts("t4");

      // random consumer stalls with gaps between bytes
      rand_ready = 1'b1;
      max_gap = 3;
      rand_pkt(30); send_pkt(1000);
      for (int p = 0; p < 4; p++) begin
         idle(TIMEOUT + 3);
         rand_pkt($urandom_range(12, 3)); send_pkt(1000);
      end
      max_gap = 0;
      idle(TIMEOUT + 5);
      wait_drain("t5_drain", 500);
      rand_ready = 1'b0;
      ready_level = 1'b1;
      idle(2);
      check_counts("t5");

      // reset in the middle of a packet
      ready_level = 1'b0;
      idle(2);
      rand_pkt(7);
      model_pkt(1000, 1'b0);
      send_range(0, 7);
      @(posedge clk); #1;
      ready_level = 1'b1;
      repeat (2) @(posedge clk);
      #1 ready_level = 1'b0;
      @(posedge clk); #1;
      chk("t6_fifo_occ", exp_q.size(), 3);
      chk("t6_valid_before", wr_valid, 1);
      rst = 1'b1;
      #1;
      chk("t6_valid", wr_valid, 0);
      chk("t6_adr", wr_adr, 0);
      chk("t6_data", wr_data, 0);
      chk("t6_first", wr_first, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_pulses", {pkt_done, err_short, err_long}, 0);
      exp_writes = exp_writes - exp_q.size();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ready_level = 1'b1;
      idle(2);
      pkt_q = '{8'h00, 8'h00, 8'hAA};
      send_pkt(1000);
      idle(TIMEOUT + 5);
      wait_drain("t6_drain", 50);
      check_counts("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/usb_rx_framer.md
# usb_rx_framer

Front-end receive framer for the Dragon board USB byte stream. It samples the USB chip's write strobe and data bus and splits the stream into packets using an idle timeout. The first two bytes of each packet are taken as a little-endian start address. Every following byte leaves the block as an (address, byte) write transaction through a small FIFO with a valid/ready handshake, so downstream register banks and blockram writers can consume writes without decoding packet framing themselves.

## Interface
Parameters:
- TIMEOUT, default 8: consecutive strobe-free clocks that end a packet (2..255).
- MAX_PKT, default 64: maximum accepted packet length in bytes, address bytes included.
- FIFO_AW, default 4: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- USB_FWRn, input, 1: USB write strobe, active low. Low at a rising edge of clk means one byte.
- USB_D, input, 8: USB data bus, sampled together with USB_FWRn.
- wr_valid, output, 1: FIFO head holds a write.
- wr_ready, input, 1: consumer accepts the head write.
- wr_adr, output, 16: write address of the head entry.
- wr_data, output, 8: write data of the head entry.
- wr_first, output, 1: head entry is the first data byte of its packet.
- pkt_done, output, 1: one-clock pulse when a packet containing at least one data byte ends.
- err_short, output, 1: one-clock pulse when a packet ends with fewer than 3 bytes.
- err_long, output, 1: one-clock pulse, once per packet, when byte MAX_PKT+1 arrives.
- overflow, output, 1: sticky. Set when a data byte is dropped because the FIFO is full; cleared only by rst.

## Operation
- Input stage: USB_FWRn and USB_D are registered once, giving strb_q = ~USB_FWRn and d_q. All framing logic uses strb_q and d_q only.
- Idle counter: cleared to 0 on strb_q. Otherwise it increments and saturates at TIMEOUT. Timeout is the cycle in which the counter becomes TIMEOUT.
- States:
  - ADR_LO: the next byte loads adr[7:0], then go to ADR_HI.
  - ADR_HI: the next byte loads adr[15:8], then go to DATA.
  - DATA: each byte pushes {adr, d_q, first} into the FIFO and then increments adr.
  - DISCARD: bytes are ignored.
- Transitions:
  - DATA goes to DISCARD when the byte count would exceed MAX_PKT; err_long pulses at that moment.
  - On timeout:
    - from ADR_HI: go to ADR_LO and pulse err_short.
    - from DATA or DISCARD: go to ADR_LO and pulse pkt_done.
    - from ADR_LO: nothing happens.
  - A packet of exactly 2 bytes ends with err_short, because its timeout occurs in DATA with no data byte pushed.
- Byte counter: 7 bits. Cleared on entry to ADR_LO. Counts every accepted byte, address bytes included.
- Address arithmetic: 16-bit with wrap-around, 0xFFFF+1 = 0x0000. adr also increments for a byte dropped on overflow, so later bytes keep their correct addresses.
- first flag: set on the first data byte of each packet only.
- FIFO behaviour:
  - First-word fall-through: wr_adr, wr_data and wr_first are valid whenever wr_valid is high.
  - Pop happens when wr_valid & wr_ready.
  - Full is judged on the occupancy at the start of the cycle. A pop in the same cycle does not make room for a push; the pushed byte is dropped and overflow is set.
  - A push and a pop in the same cycle while not full are both performed.
- pkt_done and error pulses refer to framing only. They can occur while earlier writes of the packet are still in the FIFO.

## Timing
- Reset values:
  - wr_valid = 0, wr_adr = 0, wr_data = 0, wr_first = 0.
  - pkt_done = 0, err_short = 0, err_long = 0, overflow = 0.
  - FIFO empty, state ADR_LO, idle counter = TIMEOUT, strb_q = 0.
- Reset mid-packet: the FIFO contents and the partial packet are discarded. The first strobe after rst deasserts is treated as an address-low byte.
- Latency:
  - Data byte sampled at edge N becomes d_q at N, is pushed at N+1, and wr_valid is high after N+1. That is 2 clocks into an empty FIFO.
  - Pop at edge M exposes the next entry after M.
- Outputs are stable while wr_valid & ~wr_ready. wr_valid never drops without a pop.
- Back-to-back strobes (one byte per clock) are fully supported.
- Timeout pulse: the last strobe sampled at edge N pulses pkt_done (or err_short) in the cycle after edge N+1+TIMEOUT.

## Test plan
- Send bytes 00 10 34 12 with wr_ready=1 -> writes (0x1000,0x34,first=1) and (0x1001,0x12,first=0). One pkt_done pulse TIMEOUT+1 clocks after the last strobe. No error outputs assert.
- Send 1-byte and then 2-byte packets, separated by 20 idle clocks -> no writes, and err_short pulses twice.
- Send 66-byte packet FE FF then 64 data bytes -> 62 writes with addresses 0xFFFE, 0xFFFF, 0x0000..0x003B. err_long pulses once, at byte 65. pkt_done pulses once.
- Hold wr_ready=0 and send a packet with address 0x0200 and 20 data bytes (depth 16) -> overflow sets at data byte 17. Draining yields exactly 0x0200..0x020F. A following packet's writes start at its own address.
- Toggle wr_ready randomly during a 30-byte packet -> no loss, no duplication, in-order addresses, and outputs stable while stalled.
- Assert rst after 5 data bytes while the FIFO holds 3 entries -> wr_valid drops immediately. All outputs return to reset values. The next packet 00 00 AA is decoded correctly as write (0x0000,0xAA).
